// File: rtl/nrf_pkg.sv
// Shared types and constants for the nRF24L01 SPI command controller.
// Holds FSM encodings, command opcodes and byte-lane helpers.
package nrf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SEND,
      ST_WAIT_RX,
      ST_CS_HOLD,
      ST_DONE
   } state_e;

   localparam logic [7:0] R_REGISTER = 8'h00;
   localparam logic [7:0] W_REGISTER = 8'h20;
   localparam logic [7:0] NOP        = 8'hFF;

   localparam int MAX_DATA_BYTES = 5;

   function automatic logic [7:0] byte_sel(
      input logic [39:0] d,
      input logic [2:0]  i
   );
      logic [7:0] r;
      r = 8'h00;
      case (i)
         3'd0:    r = d[7:0];
         3'd1:    r = d[15:8];
         3'd2:    r = d[23:16];
         3'd3:    r = d[31:24];
         3'd4:    r = d[39:32];
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [39:0] byte_put(
      input logic [39:0] d,
      input logic [2:0]  i,
      input logic [7:0]  b
   );
      logic [39:0] r;
      r = d;
      case (i)
         3'd0:    r[7:0]   = b;
         3'd1:    r[15:8]  = b;
         3'd2:    r[23:16] = b;
         3'd3:    r[31:24] = b;
         3'd4:    r[39:32] = b;
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/nrf_spi_cmd_ctrl.sv
// nRF24L01 command sequencer: frames opcode plus up to five data bytes
// under CSN and hands them byte-by-byte to an external SPI transceiver.
module nrf_spi_cmd_ctrl
   import nrf_pkg::*;
#(
   parameter int CS_SETUP_CYCLES = 2,
   parameter int CS_HOLD_CYCLES  = 2
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_Cmd_Valid,
   input  logic [7:0]  i_Cmd_Opcode,
   input  logic [2:0]  i_Cmd_Len,
   input  logic [39:0] i_Wr_Data,
   output logic        o_Cmd_Ready,
   output logic        o_Done,
   output logic [7:0]  o_Status,
   output logic [39:0] o_Rd_Data,
   output logic [7:0]  o_TX_Byte,
   output logic        o_TX_DV,
   input  logic        i_TX_Ready,
   input  logic        i_RX_DV,
   input  logic [7:0]  i_RX_Byte,
   output logic        o_SPI_CS_n
);

   state_e      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [2:0]  len_q, len_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [39:0] wdata_q, wdata_d;
   logic [39:0] rdata_q, rdata_d;
   logic [7:0]  status_q, status_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cs_n_q, cs_n_d;
   logic        tx_dv;
   logic [7:0]  tx_byte;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         len_q    <= '0;
         opcode_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         status_q <= '0;
         cnt_q    <= '0;
         cs_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         len_q    <= len_d;
         opcode_q <= opcode_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         cs_n_q   <= cs_n_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      len_d    = len_q;
      opcode_d = opcode_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      cnt_d    = cnt_q;
      cs_n_d   = cs_n_q;
      tx_dv    = 1'b0;
      tx_byte  = 8'h00;
      unique case (state_q)
         ST_IDLE: begin
            if (i_Cmd_Valid) begin
               opcode_d = i_Cmd_Opcode;
               len_d    = (i_Cmd_Len > 3'(MAX_DATA_BYTES)) ?
                          3'(MAX_DATA_BYTES) : i_Cmd_Len;
               wdata_d  = i_Wr_Data;
               rdata_d  = '0;
               k_d      = '0;
               cnt_d    = '0;
               cs_n_d   = 1'b0;
               state_d  = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (cnt_q == 8'(CS_SETUP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_SEND;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_SEND: begin
            tx_byte = (k_q == 3'd0) ? opcode_q :
                      byte_sel(wdata_q, k_q - 3'd1);
            if (i_TX_Ready) begin
               tx_dv   = 1'b1;
               state_d = ST_WAIT_RX;
            end
         end
         ST_WAIT_RX: begin
            if (i_RX_DV) begin
               if (k_q == 3'd0) status_d = i_RX_Byte;
               else rdata_d = byte_put(rdata_q, k_q - 3'd1, i_RX_Byte);
               if (k_q == len_q) begin
                  state_d = ST_CS_HOLD;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = ST_SEND;
               end
            end
         end
         ST_CS_HOLD: begin
            if (cnt_q == 8'(CS_HOLD_CYCLES - 1)) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_Cmd_Ready = (state_q == ST_IDLE);
   assign o_Done      = (state_q == ST_DONE);
   assign o_Status    = status_q;
   assign o_Rd_Data   = rdata_q;
   assign o_TX_Byte   = tx_byte;
   assign o_TX_DV     = tx_dv;
   assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_nrf_spi_cmd_ctrl.sv
// Bench for nrf_spi_cmd_ctrl with a loopback transceiver model
// (every byte sent comes back as the received byte).
module tb_nrf_spi_cmd_ctrl;
   import nrf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_op = 8'h00;
   logic [2:0]  cmd_len = 3'd0;
   logic [39:0] wr_data = '0;
   logic        cmd_ready, done;
   logic [7:0]  status;
   logic [39:0] rd_data;
   logic [7:0]  tx_byte;
   logic        tx_dv, tx_ready, rx_dv, cs_n;
   logic [7:0]  rx_byte;

   logic [2:0]  busy;
   logic [7:0]  cap;
   logic        m_rx_dv;
   logic [7:0]  m_rx_byte;
   logic        inj_dv = 1'b0;
   logic [7:0]  inj_byte = 8'h00;

   int checks = 0;
   int failures = 0;
   int tx_cnt = 0, done_cnt = 0, acc_cnt = 0;
   int cs_rise = 0, cs_fall = 0, cs_bad = 0;
   logic [7:0] sent[$];

   always #5 clk = ~clk;

   nrf_spi_cmd_ctrl #(.CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(2)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_Cmd_Valid(cmd_valid), .i_Cmd_Opcode(cmd_op),
      .i_Cmd_Len(cmd_len), .i_Wr_Data(wr_data),
      .o_Cmd_Ready(cmd_ready), .o_Done(done),
      .o_Status(status), .o_Rd_Data(rd_data),
      .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv),
      .i_TX_Ready(tx_ready), .i_RX_DV(rx_dv),
      .i_RX_Byte(rx_byte), .o_SPI_CS_n(cs_n)
   );

   assign tx_ready = (busy == 3'd0) && !m_rx_dv;
   assign rx_dv    = m_rx_dv | inj_dv;
   assign rx_byte  = inj_dv ? inj_byte : m_rx_byte;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 3'd0; cap <= 8'h00;
         m_rx_dv <= 1'b0; m_rx_byte <= 8'h00;
      end else begin
         m_rx_dv <= 1'b0;
         if (tx_dv && tx_ready) begin
            busy <= 3'd4;
            cap  <= tx_byte;
         end else if (busy != 3'd0) begin
            busy <= busy - 3'd1;
            if (busy == 3'd1) begin
               m_rx_dv   <= 1'b1;
               m_rx_byte <= cap;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (tx_dv) begin
            sent.push_back(tx_byte);
            tx_cnt++;
            if (cs_n) cs_bad++;
         end
         if (done) done_cnt++;
         if (cmd_valid && cmd_ready) acc_cnt++;
      end
   end

   always @(posedge cs_n) cs_rise++;
   always @(negedge cs_n) cs_fall++;

   task automatic clear_mon();
      tx_cnt = 0; done_cnt = 0; acc_cnt = 0;
      cs_rise = 0; cs_fall = 0; cs_bad = 0;
      sent.delete();
   endtask

   task automatic issue(input logic [7:0] op, input logic [2:0] len,
                        input logic [39:0] d);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_len = len; wr_data = d;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = ~op; cmd_len = 3'd2; wr_data = ~d;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 400) begin
         @(negedge clk); n++;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt < target) begin
         failures++;
         $display("FAIL done_timeout got=%0d want=%0d", done_cnt, target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (cs_n !== 1'b1 || tx_dv !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl cs_n=%b tx_dv=%b done=%b want 1 0 0",
                  cs_n, tx_dv, done);
      end
      checks++;
      if (tx_byte !== 8'h00 || status !== 8'h00 || rd_data !== 40'h0) begin
         failures++;
         $display("FAIL reset_data tx=%h st=%h rd=%h want 0", tx_byte,
                  status, rd_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_nop();
      clear_mon();
      issue(NOP, 3'd0, 40'h00DEADBEEF);
      wait_done(1);
      checks++;
      if (tx_cnt !== 1 || sent.size() < 1 || sent[0] !== 8'hFF) begin
         failures++;
         $display("FAIL nop_tx cnt=%0d want=1 byte0 want=ff", tx_cnt);
      end
      checks++;
      if (status !== 8'hFF || rd_data !== 40'h0) begin
         failures++;
         $display("FAIL nop_rx st=%h rd=%h want ff 0", status, rd_data);
      end
      checks++;
      if (done_cnt !== 1 || cs_fall !== 1 || cs_rise !== 1 || cs_bad !== 0) begin
         failures++;
         $display("FAIL nop_frame done=%0d fall=%0d rise=%0d bad=%0d want 1 1 1 0",
                  done_cnt, cs_fall, cs_rise, cs_bad);
      end
   endtask

   task automatic test_stray_rx();
      int t0;
      t0 = tx_cnt;
      inj_byte = 8'h5A;
      @(negedge clk); inj_dv = 1'b1;
      @(negedge clk); inj_dv = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (status !== 8'hFF || rd_data !== 40'h0 || tx_cnt !== t0) begin
         failures++;
         $display("FAIL stray_rx st=%h rd=%h tx=%0d want ff 0 %0d",
                  status, rd_data, tx_cnt, t0);
      end
   endtask

   task automatic test_len5();
      logic [7:0] exp_b[6];
      exp_b = '{8'h2A, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      clear_mon();
      issue(8'h2A, 3'd5, 40'h1122334455);
      wait_done(1);
      checks++;
      if (tx_cnt !== 6) begin
         failures++;
         $display("FAIL len5_count got=%0d want=6", tx_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (sent.size() <= i || sent[i] !== exp_b[i]) begin
            failures++;
            $display("FAIL len5_byte%0d got=%h want=%h", i,
                     (sent.size() > i) ? sent[i] : 8'hxx, exp_b[i]);
         end
      end
      checks++;
      if (status !== 8'h2A || rd_data !== 40'h1122334455) begin
         failures++;
         $display("FAIL len5_rx st=%h rd=%h want 2a 1122334455", status, rd_data);
      end
      checks++;
      if (cs_fall !== 1 || cs_rise !== 1 || cs_bad !== 0) begin
         failures++;
         $display("FAIL len5_csn fall=%0d rise=%0d bad=%0d want 1 1 0",
                  cs_fall, cs_rise, cs_bad);
      end
   endtask

   task automatic test_wreg1();
      clear_mon();
      issue(8'h25, 3'd1, 40'hAABBCCDD02);
      wait_done(1);
      checks++;
      if (tx_cnt !== 2 || sent.size() < 2 || sent[0] !== 8'h25 ||
          sent[1] !== 8'h02) begin
         failures++;
         $display("FAIL wreg1_tx cnt=%0d want 2 bytes 25 02", tx_cnt);
      end
      checks++;
      if (status !== 8'h25 || rd_data !== 40'h0000000002) begin
         failures++;
         $display("FAIL wreg1_rx st=%h rd=%h want 25 0000000002", status, rd_data);
      end
   endtask

   task automatic test_len7();
      clear_mon();
      issue(8'h2A, 3'd7, 40'h0102030405);
      wait_done(1);
      checks++;
      if (tx_cnt !== 6 || rd_data !== 40'h0102030405) begin
         failures++;
         $display("FAIL len7_clamp cnt=%0d rd=%h want 6 0102030405",
                  tx_cnt, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int bad = 0;
      clear_mon();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 8'h20; cmd_len = 3'd1; wr_data = 40'h07;
      @(negedge clk);
      while (!done && n < 400) begin
         if (cmd_ready) bad++;
         @(negedge clk); n++;
      end
      checks++;
      if (cmd_ready !== 1'b0 || bad !== 0) begin
         failures++;
         $display("FAIL b2b_busy ready=%b bad=%0d want 0 0", cmd_ready, bad);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready_after_done got=%b want=1", cmd_ready);
      end
      cmd_op = 8'hFF; cmd_len = 3'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(2);
      checks++;
      if (acc_cnt !== 2 || done_cnt !== 2) begin
         failures++;
         $display("FAIL b2b_accepts acc=%0d done=%0d want 2 2", acc_cnt, done_cnt);
      end
      checks++;
      if (sent.size() !== 3 || sent[0] !== 8'h20 || sent[1] !== 8'h07 ||
          sent[2] !== 8'hFF) begin
         failures++;
         $display("FAIL b2b_bytes n=%0d want 3 bytes 20 07 ff", sent.size());
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_mon();
      issue(8'h2B, 3'd3, 40'h0000332211);
      while (tx_cnt < 3 && n < 400) begin
         @(negedge clk); n++;
      end
      checks++;
      if (tx_cnt < 3) begin
         failures++;
         $display("FAIL rmid_timeout tx=%0d want=3", tx_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (cs_n !== 1'b1 || tx_dv !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rmid_ctl cs_n=%b tx_dv=%b done=%b want 1 0 0",
                  cs_n, tx_dv, done);
      end
      checks++;
      if (tx_byte !== 8'h00 || status !== 8'h00 || rd_data !== 40'h0) begin
         failures++;
         $display("FAIL rmid_data tx=%h st=%h rd=%h want 0", tx_byte,
                  status, rd_data);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmid_ready got=%b want=1", cmd_ready);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt !== 0 || tx_cnt !== 3 || cs_n !== 1'b1) begin
         failures++;
         $display("FAIL rmid_abort done=%0d tx=%0d cs_n=%b want 0 3 1",
                  done_cnt, tx_cnt, cs_n);
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_stray_rx();
      test_len5();
      test_wreg1();
      test_len7();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nrf_spi_cmd_ctrl.md
NRF_SPI_CMD_CTRL -- requirements
Module: nrf_spi_cmd_ctrl

Interface
REQ-001 Parameter CS_SETUP_CYCLES, default 2: i_Clk cycles from CSN falling to the first byte request.
REQ-002 Parameter CS_HOLD_CYCLES, default 2: i_Clk cycles from the last received byte to CSN rising.
REQ-003 i_Clk  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 i_Rst_L  in  1  reset, asynchronous, active-low.
REQ-005 i_Cmd_Valid  in  1  command request.
REQ-006 i_Cmd_Opcode  in  8  nRF24L01 command byte (e.g. 0x00|addr = R_REGISTER, 0x20|addr = W_REGISTER, 0xFF = NOP).
REQ-007 i_Cmd_Len  in  3  number of data bytes after the opcode, 0..5.
REQ-008 i_Wr_Data  in  40  MOSI data bytes; byte 0 = bits [7:0], sent first.
REQ-009 o_Cmd_Ready  out  1  controller idle; accepts a command.
REQ-010 o_Done  out  1  one-cycle pulse when a command completes.
REQ-011 o_Status  out  8  first MISO byte (STATUS register).
REQ-012 o_Rd_Data  out  40  MISO data bytes; byte 0 = bits [7:0].
REQ-013 o_TX_Byte  out  8  byte to the SPI transceiver.
REQ-014 o_TX_DV  out  1  one-cycle strobe for o_TX_Byte.
REQ-015 i_TX_Ready  in  1  transceiver can accept a byte.
REQ-016 i_RX_DV  in  1  transceiver received-byte strobe.
REQ-017 i_RX_Byte  in  8  received byte, valid with i_RX_DV.
REQ-018 o_SPI_CS_n  out  1  nRF24L01 CSN, active-low.

Function
REQ-019 FSM states: IDLE, CS_SETUP, SEND, WAIT_RX, CS_HOLD, DONE.
REQ-020 o_Cmd_Ready shall be 1 only in IDLE. A command is accepted on a cycle with i_Cmd_Valid=1 and o_Cmd_Ready=1.
REQ-021 On accept:
- latch opcode, length and write data;
- clear o_Rd_Data;
- set byte index k=0;
- drive o_SPI_CS_n=0 from the next cycle;
- enter CS_SETUP.
REQ-022 i_Cmd_Len values 6 and 7 shall be treated as 5.
REQ-023 CS_SETUP lasts exactly CS_SETUP_CYCLES cycles, then enters SEND.
REQ-024 SEND: on the first cycle with i_TX_Ready=1, assert o_TX_DV for exactly one cycle, then enter WAIT_RX.
- k=0: o_TX_Byte = opcode.
- k>=1: o_TX_Byte = write byte k-1.
REQ-025 WAIT_RX: on i_RX_DV=1, store i_RX_Byte.
- k=0: into o_Status.
- k>=1: into o_Rd_Data byte k-1.
- If k = length: enter CS_HOLD; otherwise k increments and the FSM returns to SEND.
REQ-026 i_RX_DV outside WAIT_RX shall be ignored. o_TX_DV shall never be asserted outside SEND.
REQ-027 CS_HOLD lasts CS_HOLD_CYCLES cycles. Then o_SPI_CS_n=1 and the FSM enters DONE.
REQ-028 DONE: o_Done=1 for one cycle, then IDLE.
- o_Status and o_Rd_Data remain stable until the next accept.
- Unused o_Rd_Data bytes read 0.
REQ-029 o_SPI_CS_n shall stay low continuously from CS_SETUP through CS_HOLD. No glitch between bytes.
REQ-030 Unused i_Wr_Data bytes shall be ignored. i_Wr_Data changes after accept shall have no effect.

Reset
REQ-031 While i_Rst_L=0, at any time including mid-command:
- o_SPI_CS_n=1;
- o_TX_DV=0, o_Done=0;
- o_TX_Byte=0x00, o_Status=0x00, o_Rd_Data=0;
- FSM = IDLE.
REQ-032 o_Cmd_Ready shall be 1 from the first cycle after i_Rst_L rises. An aborted command produces no o_Done.

Structure
REQ-033 Shared package nrf_pkg shall hold:
- FSM state encodings;
- opcode constants R_REGISTER=0x00, W_REGISTER=0x20, NOP=0xFF;
- MAX_DATA_BYTES=5.
REQ-034 There shall be no sub-module. The block instantiates no transceiver; the integrator connects it to spi_transceiver at top level.

Verification
REQ-035 The bench shall instantiate nrf_spi_cmd_ctrl with spi_transceiver, MISO looped to MOSI, and cover these scenarios:
- NOP 0xFF, len 0 -> one o_TX_DV with 0xFF; o_Status=0xFF; o_Rd_Data=0; exactly one o_Done; CSN low for the whole transfer.
- Opcode 0x25, len 1, data 0x02 -> bytes 0x25, 0x02 on the bus; o_Status=0x25; o_Rd_Data=40'h0000000002.
- Opcode 0x2A, len 5, data 40'h1122334455 -> bus order 0x2A, 0x55, 0x44, 0x33, 0x22, 0x11; o_Rd_Data=40'h1122334455; CSN never high between bytes.
- i_Cmd_Valid held high through a command -> o_Cmd_Ready=0 until the cycle after o_Done; the second command is accepted exactly once.
- i_Rst_L pulsed low during byte 2 of a len-3 command -> CSN=1 and o_TX_DV=0 immediately; no o_Done; o_Cmd_Ready=1 one cycle after release.
- Len 7, opcode 0x2A -> exactly 6 bytes sent (treated as len 5).
